// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle, operating on
// operand magnitudes with a final sign fix-up. Divide-by-zero and signed
// overflow finish through a single-cycle fast path.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Flush,
  input  logic                     Start,
  input  logic [CONTROL_WIDTH-1:0] MulDivControl,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_e;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return ~v + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  state_e                   state_q;
  logic [2:0]               op_q;
  logic [W-1:0]             a_q, b_q, result_q;
  logic [2*W-1:0]           acc_q;
  logic                     neg_q, busy_q, done_q;
  logic [CW-1:0]            cnt_q;

  logic [2:0]               op_s;
  logic                     a_neg_s, b_neg_s, sign_d, fast_s;
  logic [W-1:0]             a_mag_s, b_mag_s, fast_res_s, final_d, div_val_s;
  logic [2*W-1:0]           acc_init_d, acc_d, mul_next_s, div_next_s, prod_s;
  logic [W:0]               mul_sum_s, div_diff_s;

  assign op_s = MulDivControl[2:0];

  // Accept-time decode: operand magnitudes, result sign and fast-path result
  always_comb begin
    // MULHU/DIVU/REMU are unsigned in both; MULHSU signed only in A
    a_neg_s = SrcA[W-1] & ~((op_s == 3'b011) | (op_s == 3'b101) | (op_s == 3'b111));
    b_neg_s = SrcB[W-1] & ~((op_s == 3'b010) | (op_s == 3'b011) |
                            (op_s == 3'b101) | (op_s == 3'b111));
    a_mag_s = a_neg_s ? neg_w(SrcA) : SrcA;
    b_mag_s = b_neg_s ? neg_w(SrcB) : SrcB;
    // remainder follows the dividend; quotient and product follow the XOR
    if (op_s[2] && op_s[1]) begin
      sign_d = a_neg_s;
    end else begin
      sign_d = a_neg_s ^ b_neg_s;
    end
    if (op_s[2]) begin
      acc_init_d = {{W{1'b0}}, a_mag_s};
    end else begin
      acc_init_d = {{W{1'b0}}, b_mag_s};
    end
    fast_s = 1'b0;
    fast_res_s = {W{1'b0}};
    if (op_s[2] && (SrcB == {W{1'b0}})) begin
      fast_s = 1'b1;
      fast_res_s = op_s[1] ? SrcA : {W{1'b1}};
    end else if (op_s[2] && !op_s[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) &&
                 (SrcB == {W{1'b1}})) begin
      fast_s = 1'b1;
      fast_res_s = op_s[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}};
    end else begin
      fast_s = 1'b0;
      fast_res_s = {W{1'b0}};
    end
  end

  // One iteration step and the final sign fix-up / half selection
  always_comb begin
    // multiply: add multiplicand into the high half when LSB set, then shift right
    mul_sum_s  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? a_q : {W{1'b0}})};
    mul_next_s = {mul_sum_s, acc_q[W-1:1]};
    // divide: shift {rem,quo} left, trial-subtract the divisor from the top
    div_diff_s = acc_q[2*W-1:W-1] - {1'b0, b_q};
    if (!div_diff_s[W]) begin
      div_next_s = {div_diff_s[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next_s = {acc_q[2*W-2:W-1], acc_q[W-2:0], 1'b0};
    end
    acc_d = op_q[2] ? div_next_s : mul_next_s;
    prod_s = neg_q ? neg_2w(acc_q) : acc_q;
    div_val_s = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
    if (op_q[2]) begin
      final_d = neg_q ? neg_w(div_val_s) : div_val_s;
    end else if (op_q[1:0] == 2'b00) begin
      final_d = prod_s[W-1:0];
    end else begin
      final_d = prod_s[2*W-1:W];
    end
  end

  // Control FSM with datapath registers and registered Busy/Done/Result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 3'b000;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      acc_q    <= {(2*W){1'b0}};
      neg_q    <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {W{1'b0}};
    end else if (Flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            op_q  <= op_s;
            a_q   <= a_mag_s;
            b_q   <= b_mag_s;
            acc_q <= acc_init_d;
            neg_q <= sign_d;
            cnt_q <= CW'(W);
            if (fast_s) begin
              result_q <= fast_res_s;
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        CALC: begin
          if (cnt_q != {CW{1'b0}}) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end else begin
            result_q <= final_d;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a
// monitor pops and compares on every Done pulse.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Flush = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MulDivControl = 3'b000;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        Busy, Done;
  logic [31:0] Result;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  muldiv_unit #(.DATA_WIDTH(32), .CONTROL_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .Start(Start),
    .MulDivControl(MulDivControl), .SrcA(SrcA), .SrcB(SrcB),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && Busy && Done) begin
      fails++;
      $display("FAIL busy_done_overlap: got Busy=1 Done=1, expected not both");
    end
    if (rst_n && Done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got Result 0x%08h, expected no Done", Result);
      end else begin
        check(name_q.pop_front(), Result, exp_q.pop_front());
      end
    end
  end

  // Issue one operation, then check latency, Busy length and Done width.
  // poke >= 0 raises Start for one cycle while the op is in flight.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int poke,
                        input string nm);
    int n;
    int busy_n;
    @(negedge clk);
    Start = 1'b1; MulDivControl = op; SrcA = a; SrcB = b;
    exp_q.push_back(exp); name_q.push_back(nm);
    @(posedge clk); #1;
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    n = 0; busy_n = 0;
    while (!Done && n < 100) begin
      if (Busy) busy_n++;
      if (n == poke) Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      n++;
    end
    check({nm, "_latency"}, n, exp_lat);
    check({nm, "_busy_cycles"}, busy_n, exp_lat);
    @(posedge clk); #1;
    check({nm, "_done_drop"}, {31'd0, Done}, 32'd0);
    check({nm, "_busy_after"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    int n;
    int done_seen;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_result", Result, 32'd0);
    rst_n = 1'b1;

    run_op(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT, -1, "mul_7_m3");
    run_op(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT, -1, "mulh_min");
    run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT, -1, "mulhu_max");
    run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT, -1, "mulhsu_max");
    run_op(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT, -1, "div_m7_2");
    run_op(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT, -1, "rem_m7_2");
    run_op(OP_DIVU,   32'd100,      32'd7,        32'd14,       LAT, 5,  "divu_100_7_poke");
    run_op(OP_REMU,   32'd100,      32'd7,        32'd2,        LAT, -1, "remu_100_7");
    run_op(OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 0,   -1, "div_by_zero");
    run_op(OP_REMU,   32'd5,        32'd0,        32'd5,        0,   -1, "remu_by_zero");
    run_op(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0,   -1, "rem_ovf");
    run_op(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,   -1, "div_ovf");

    // Flush on cycle 10 of a DIVU: no Done, Result keeps 0x80000000
    @(negedge clk);
    Start = 1'b1; MulDivControl = OP_DIVU; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1; Start = 1'b0;
    repeat (10) @(posedge clk);
    #1; Flush = 1'b1;
    @(posedge clk); #1; Flush = 1'b0;
    check("flush_busy", {31'd0, Busy}, 32'd0);
    check("flush_result", Result, 32'h80000000);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (Done) done_seen++;
    end
    check("flush_no_done", done_seen, 32'd0);

    // Start and Flush together in IDLE: nothing accepted
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1; MulDivControl = OP_MUL; SrcA = 32'd2; SrcB = 32'd2;
    @(posedge clk); #1; Start = 1'b0; Flush = 1'b0;
    check("startflush_busy", {31'd0, Busy}, 32'd0);
    check("startflush_done", {31'd0, Done}, 32'd0);
    @(posedge clk); #1;
    check("startflush_busy2", {31'd0, Busy}, 32'd0);

    // Back-to-back: DIVU accepted in the Done cycle of MUL 3 x 4
    @(negedge clk);
    Start = 1'b1; MulDivControl = OP_MUL; SrcA = 32'd3; SrcB = 32'd4;
    exp_q.push_back(32'd12); name_q.push_back("b2b_mul");
    @(posedge clk); #1; Start = 1'b0;
    n = 0;
    while (!Done && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b_mul_latency", n, LAT);
    Start = 1'b1; MulDivControl = OP_DIVU; SrcA = 32'd9; SrcB = 32'd3;
    exp_q.push_back(32'd3); name_q.push_back("b2b_divu");
    @(posedge clk); #1; Start = 1'b0;
    check("b2b_done_drop", {31'd0, Done}, 32'd0);
    check("b2b_busy_nogap", {31'd0, Busy}, 32'd1);
    n = 0;
    while (!Done && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b_divu_latency", n, LAT);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    Start = 1'b1; MulDivControl = OP_MUL; SrcA = 32'd5; SrcB = 32'd5;
    @(posedge clk); #1; Start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_result", Result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MUL, 32'd2, 32'd2, 32'd4, LAT, -1, "mul_after_rst");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU. Computes all eight M-extension operations: shift-add multiply (one bit per cycle) and restoring divide (one bit per cycle). Start/Busy/Done handshake lets the hazard unit stall the pipeline while an operation is in flight. Divide-by-zero and signed overflow complete on a one-cycle fast path.

## Interface
- DATA_WIDTH, 32, operand and result width W (even, ≥ 8)
- CONTROL_WIDTH, 3, width of MulDivControl (RV32M funct3)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Flush  in  1  synchronous abort of the in-flight operation
- Start  in  1  request; sampled on rising edge
- MulDivControl  in  CONTROL_WIDTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  DATA_WIDTH  multiplicand / dividend
- SrcB  in  DATA_WIDTH  multiplier / divisor
- Busy  out  1  operation in progress; new Start ignored
- Done  out  1  one-cycle pulse; Result valid
- Result  out  DATA_WIDTH  registered result, held until next write

## Operation
- States: IDLE, CALC, DONE. Reset: state IDLE, Busy 0, Done 0, Result 0, all internal registers 0.
- Start is accepted in IDLE or DONE with Flush low. Start while Busy is 1 is ignored (no latch, no error).
- Accept latches op, |SrcA|, |SrcB| (magnitudes only for signed operands), result-sign flag, iteration counter = W.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats SrcA as signed and SrcB as unsigned. MULHU/DIVU/REMU treat both as unsigned.
- Multiply: 2W-bit product accumulator, one shift-add per CALC cycle. Final two's-complement negate if the sign flag is set. MUL returns the low W bits; MULH/MULHSU/MULHU return the high W bits.
- Divide: restoring, one quotient bit per CALC cycle. Quotient is negated if operand signs differ (DIV). Remainder takes the sign of the dividend (REM).
- Fast path, taken at accept with no CALC:
  - SrcB = 0: DIV/DIVU give all-ones; REM/REMU give SrcA.
  - DIV/REM with SrcA = 2^(W-1) and SrcB = all-ones: DIV gives 2^(W-1); REM gives 0.
- CALC → DONE when the counter reaches 0. DONE → IDLE after one cycle unless Start is accepted there (back-to-back).
- Flush in any state: next state IDLE, Busy 0, no Done, Result unchanged. Flush and Start in the same cycle: Flush wins, Start dropped.
- rst_n low mid-operation: immediate return to reset values. The operation is lost.

## Timing
- Accept edge is edge 0. Iterations occur on edges 1..W. Edge W+1 writes Result and enters DONE.
- Busy = 1 from after edge 0 through edge W+1 (W+1 cycles). Done = 1 for exactly the one cycle after edge W+1.
- Latency: W+1 cycles (33 at W=32). Fast path: Result written and Done = 1 in the cycle immediately after edge 0; Busy stays 0.
- Busy and Done are never 1 together.
- Operands may change after the accept edge without effect.
- Back-to-back: Start during the Done cycle is accepted; Done drops the next cycle.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → Result 0xFFFFFFEB. Done exactly 33 cycles after accept. Busy high 33 cycles, low thereafter.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM of the same → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Fast path:
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - Each: Done one cycle after accept, Busy never high.
- Flush and Start handling:
  - Flush on cycle 10 of a DIVU: Busy low next cycle, Done never pulses, Result keeps its prior value.
  - Start pulsed while Busy: ignored.
  - Start and Flush together in IDLE: nothing accepted.
- Back-to-back and reset:
  - Start in the Done cycle of MUL 3 × 4 (→ 12), followed by DIVU 9 / 3 → 3. No idle gap.
  - rst_n pulled low mid-CALC: Busy, Done and Result read 0 before the next clock edge. After release, a fresh MUL 2 × 2 → 4.
